// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle controller.
// Optional perf counters are enabled with MC_PERF_COUNT_EN.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_INIT     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_R     = 4'd5,
    S_WB_I     = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_MEM_WB   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_LW    = 4'b0010;
  localparam logic [3:0] OP_SW    = 4'b0011;
  localparam logic [3:0] OP_BEQ   = 4'b0100;
  localparam logic [3:0] OP_BNE   = 4'b0101;
  localparam logic [3:0] OP_J     = 4'b0110;
  localparam logic [3:0] OP_SLTI  = 4'b0111;

  localparam logic [2:0] FN_AND = 3'b000;
  localparam logic [2:0] FN_OR  = 3'b001;
  localparam logic [2:0] FN_ADD = 3'b010;
  localparam logic [2:0] FN_SUB = 3'b011;
  localparam logic [2:0] FN_SLT = 3'b100;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_control_fsm_alu_op_decode.sv
// ALU operation select from state, opcode and funct.
// Flags R-type funct codes with no ALU mapping.
module alu_op_decode
  import mc_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic [3:0] opcode,
  input  logic [2:0] funct,
  output logic [3:0] alu_op,
  output logic       illegal_funct
);

  always_comb begin
    alu_op        = ALU_AND;
    illegal_funct = 1'b0;
    case (state)
      S_FETCH,
      S_DECODE,
      S_MEM_ADDR: alu_op = ALU_ADD;
      S_EXEC_I: begin
        alu_op = (opcode == OP_SLTI) ?
                 ALU_SLT : ALU_ADD;
      end
      S_BRANCH: alu_op = ALU_SUB;
      S_EXEC_R: begin
        case (funct)
          FN_AND: alu_op = ALU_AND;
          FN_OR:  alu_op = ALU_OR;
          FN_ADD: alu_op = ALU_ADD;
          FN_SUB: alu_op = ALU_SUB;
          FN_SLT: alu_op = ALU_SLT;
          default: illegal_funct = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle controller sequencing the 16-bit datapath.
// Define MC_PERF_COUNT_EN to add CYCLE_CNT/INSTR_CNT.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 0
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [3:0] OPCODE,
  input  logic [2:0] FUNCT,
  input  logic       ZERO,
  output logic       PC_WRITE,
  output logic       IR_WRITE,
  output logic       IORD,
  output logic       MEM_READ,
  output logic       MEM_WRITE,
  output logic       REG_WRITE,
  output logic       REG_DST,
  output logic       MEM_TO_REG,
  output logic       ALU_SRC_A,
  output logic [1:0] ALU_SRC_B,
  output logic [1:0] PC_SRC,
  output logic [3:0] ALU_OP,
  output logic       ILLEGAL,
`ifdef MC_PERF_COUNT_EN
  output logic [31:0] CYCLE_CNT,
  output logic [31:0] INSTR_CNT,
`endif
  output logic [3:0] STATE
);

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       mem_done;
  logic       ill_op;
  logic       ill_fn;

  assign mem_done = (cnt_q == LAT);

  alu_op_decode u_alu_op_decode (
    .state         (state_q),
    .opcode        (OPCODE),
    .funct         (FUNCT),
    .alu_op        (ALU_OP),
    .illegal_funct (ill_fn)
  );

  always_comb begin
    state_d = state_q;
    ill_op  = 1'b0;
    unique case (state_q)
      S_INIT:  state_d = S_FETCH;
      S_FETCH: if (mem_done) state_d = S_DECODE;
      S_DECODE: begin
        unique case (OPCODE)
          OP_RTYPE:         state_d = S_EXEC_R;
          OP_ADDI, OP_SLTI: state_d = S_EXEC_I;
          OP_LW, OP_SW:     state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:   state_d = S_BRANCH;
          OP_J:             state_d = S_JUMP;
          default: begin
            state_d = S_FETCH;
            ill_op  = 1'b1;
          end
        endcase
      end
      S_EXEC_R: state_d = ill_fn ? S_FETCH : S_WB_R;
      S_EXEC_I: state_d = S_WB_I;
      S_MEM_ADDR: begin
        state_d = (OPCODE == OP_SW) ?
                  S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: if (mem_done) state_d = S_MEM_WB;
      S_MEM_WR: if (mem_done) state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Counter only runs while a memory state holds.
  always_comb begin
    cnt_d = 4'd0;
    if (state_d == state_q &&
        (state_q == S_FETCH ||
         state_q == S_MEM_RD ||
         state_q == S_MEM_WR))
      cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= S_INIT;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    PC_WRITE   = 1'b0;
    IR_WRITE   = 1'b0;
    IORD       = 1'b0;
    MEM_READ   = 1'b0;
    MEM_WRITE  = 1'b0;
    REG_WRITE  = 1'b0;
    REG_DST    = 1'b0;
    MEM_TO_REG = 1'b0;
    ALU_SRC_A  = 1'b0;
    ALU_SRC_B  = SRCB_REGB;
    PC_SRC     = PCSRC_ALU;
    unique case (state_q)
      S_FETCH: begin
        MEM_READ  = 1'b1;
        ALU_SRC_B = SRCB_ONE;
        IR_WRITE  = mem_done;
        PC_WRITE  = mem_done;
      end
      S_DECODE: ALU_SRC_B = SRCB_BOFF;
      S_EXEC_R: ALU_SRC_A = 1'b1;
      S_EXEC_I, S_MEM_ADDR: begin
        ALU_SRC_A = 1'b1;
        ALU_SRC_B = SRCB_IMM;
      end
      S_WB_R: begin
        REG_WRITE = 1'b1;
        REG_DST   = 1'b1;
      end
      S_WB_I: REG_WRITE = 1'b1;
      S_MEM_RD: begin
        IORD     = 1'b1;
        MEM_READ = 1'b1;
      end
      S_MEM_WR: begin
        IORD      = 1'b1;
        MEM_WRITE = 1'b1;
      end
      S_MEM_WB: begin
        REG_WRITE  = 1'b1;
        MEM_TO_REG = 1'b1;
      end
      S_BRANCH: begin
        ALU_SRC_A = 1'b1;
        PC_SRC    = PCSRC_ALUOUT;
        PC_WRITE  = (OPCODE == OP_BNE) ?
                    ~ZERO : ZERO;
      end
      S_JUMP: begin
        PC_SRC   = PCSRC_JUMP;
        PC_WRITE = 1'b1;
      end
      default: ;
    endcase
  end

  assign ILLEGAL = ill_op | ill_fn;
  assign STATE   = state_q;

`ifdef MC_PERF_COUNT_EN
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] ins_q, ins_d;
  logic        retire;

  assign retire = (state_d == S_FETCH) &&
                  (state_q == S_WB_R   ||
                   state_q == S_WB_I   ||
                   state_q == S_MEM_WR ||
                   state_q == S_MEM_WB ||
                   state_q == S_BRANCH ||
                   state_q == S_JUMP);

  always_comb begin
    cyc_d = cyc_q;
    ins_d = ins_q;
    if (state_q != S_INIT) cyc_d = cyc_q + 32'd1;
    if (retire)            ins_d = ins_q + 32'd1;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      cyc_q <= 32'd0;
      ins_q <= 32'd0;
    end else begin
      cyc_q <= cyc_d;
      ins_q <= ins_d;
    end
  end

  assign CYCLE_CNT = cyc_q;
  assign INSTR_CNT = ins_q;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench: MEM_LAT=0 and MEM_LAT=2 controllers.
// Expected per-cycle output vectors are queued then compared.
module tb_mc_control_fsm;

  logic       clk;
  logic       rst0, rst2, sel;
  logic [3:0] op_i;
  logic [2:0] fn_i;
  logic       z_i;

  logic       pcw0, irw0, iord0, mr0, mw0, rw0, rd0, m2r0, sa0, ill0;
  logic [1:0] sb0, ps0;
  logic [3:0] alu0, st0;
  logic       pcw2, irw2, iord2, mr2, mw2, rw2, rd2, m2r2, sa2, ill2;
  logic [1:0] sb2, ps2;
  logic [3:0] alu2, st2;
`ifdef MC_PERF_COUNT_EN
  logic [31:0] cyc0, ins0, cyc2, ins2;
`endif

  logic [21:0] obs0, obs2;
  assign obs0 = {st0, pcw0, irw0, iord0, mr0, mw0, rw0,
                 rd0, m2r0, sa0, sb0, ps0, alu0, ill0};
  assign obs2 = {st2, pcw2, irw2, iord2, mr2, mw2, rw2,
                 rd2, m2r2, sa2, sb2, ps2, alu2, ill2};

  // {state, pcw irw iord mr mw rw rdst m2r, srcA, srcB, pcsrc, aluop, ill}
  localparam logic [21:0] INIT0 = 22'd0;
  localparam logic [21:0] FE_W =
    {4'd1, 8'b00010000, 1'b0, 2'b01, 2'b00, 4'b0010, 1'b0};
  localparam logic [21:0] FE_L =
    {4'd1, 8'b11010000, 1'b0, 2'b01, 2'b00, 4'b0010, 1'b0};
  localparam logic [21:0] DEC =
    {4'd2, 8'b00000000, 1'b0, 2'b11, 2'b00, 4'b0010, 1'b0};
  localparam logic [21:0] DEC_ILL =
    {4'd2, 8'b00000000, 1'b0, 2'b11, 2'b00, 4'b0010, 1'b1};
  localparam logic [21:0] EXR_ADD =
    {4'd3, 8'b00000000, 1'b1, 2'b00, 2'b00, 4'b0010, 1'b0};
  localparam logic [21:0] EXR_ILL =
    {4'd3, 8'b00000000, 1'b1, 2'b00, 2'b00, 4'b0000, 1'b1};
  localparam logic [21:0] EXI_ADD =
    {4'd4, 8'b00000000, 1'b1, 2'b10, 2'b00, 4'b0010, 1'b0};
  localparam logic [21:0] EXI_SLT =
    {4'd4, 8'b00000000, 1'b1, 2'b10, 2'b00, 4'b0111, 1'b0};
  localparam logic [21:0] WBR =
    {4'd5, 8'b00000110, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0};
  localparam logic [21:0] WBI =
    {4'd6, 8'b00000100, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0};
  localparam logic [21:0] MADR =
    {4'd7, 8'b00000000, 1'b1, 2'b10, 2'b00, 4'b0010, 1'b0};
  localparam logic [21:0] MRD =
    {4'd8, 8'b00110000, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0};
  localparam logic [21:0] MWR =
    {4'd9, 8'b00101000, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0};
  localparam logic [21:0] MWB =
    {4'd10, 8'b00000101, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0};
  localparam logic [21:0] BR_T =
    {4'd11, 8'b10000000, 1'b1, 2'b00, 2'b01, 4'b0110, 1'b0};
  localparam logic [21:0] BR_N =
    {4'd11, 8'b00000000, 1'b1, 2'b00, 2'b01, 4'b0110, 1'b0};
  localparam logic [21:0] JMP =
    {4'd12, 8'b10000000, 1'b0, 2'b00, 2'b10, 4'b0000, 1'b0};

  int errs   = 0;
  int checks = 0;
  logic [21:0] sb_q[$];

  mc_control_fsm #(.MEM_LAT(0)) dut0 (
    .CLK(clk), .RESET_N(rst0), .OPCODE(op_i),
    .FUNCT(fn_i), .ZERO(z_i), .PC_WRITE(pcw0),
    .IR_WRITE(irw0), .IORD(iord0), .MEM_READ(mr0),
    .MEM_WRITE(mw0), .REG_WRITE(rw0), .REG_DST(rd0),
    .MEM_TO_REG(m2r0), .ALU_SRC_A(sa0), .ALU_SRC_B(sb0),
    .PC_SRC(ps0), .ALU_OP(alu0), .ILLEGAL(ill0),
`ifdef MC_PERF_COUNT_EN
    .CYCLE_CNT(cyc0), .INSTR_CNT(ins0),
`endif
    .STATE(st0)
  );

  mc_control_fsm #(.MEM_LAT(2)) dut2 (
    .CLK(clk), .RESET_N(rst2), .OPCODE(op_i),
    .FUNCT(fn_i), .ZERO(z_i), .PC_WRITE(pcw2),
    .IR_WRITE(irw2), .IORD(iord2), .MEM_READ(mr2),
    .MEM_WRITE(mw2), .REG_WRITE(rw2), .REG_DST(rd2),
    .MEM_TO_REG(m2r2), .ALU_SRC_A(sa2), .ALU_SRC_B(sb2),
    .PC_SRC(ps2), .ALU_OP(alu2), .ILLEGAL(ill2),
`ifdef MC_PERF_COUNT_EN
    .CYCLE_CNT(cyc2), .INSTR_CNT(ins2),
`endif
    .STATE(st2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drain(input string tag);
    logic [21:0] e;
    int k;
    k = 0;
    while (sb_q.size() > 0) begin
      @(negedge clk);
      e = sb_q.pop_front();
      chk($sformatf("%s[%0d]", tag, k),
          32'(sel ? obs2 : obs0), 32'(e));
      k++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic instr(input logic [3:0] op,
                       input logic [2:0] fn,
                       input logic z);
    op_i = op;
    fn_i = fn;
    z_i  = z;
  endtask

  initial begin
    rst0 = 1'b0; rst2 = 1'b0; sel = 1'b0;
    op_i = 4'd0; fn_i = 3'd0; z_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset0", 32'(obs0), 32'(INIT0));
    chk("reset2", 32'(obs2), 32'(INIT0));
    rst0 = 1'b1;
    @(posedge clk);
    #1;

    instr(4'b0000, 3'b010, 1'b0);
    sb_q.push_back(FE_L); sb_q.push_back(DEC);
    sb_q.push_back(EXR_ADD); sb_q.push_back(WBR);
    drain("add");
    instr(4'b0011, 3'b000, 1'b0);
    sb_q.push_back(FE_L); sb_q.push_back(DEC);
    sb_q.push_back(MADR); sb_q.push_back(MWR);
    drain("sw");
    instr(4'b0110, 3'b000, 1'b0);
    sb_q.push_back(FE_L); sb_q.push_back(DEC);
    sb_q.push_back(JMP);
    drain("j");
`ifdef MC_PERF_COUNT_EN
    chk("instr_cnt", ins0, 32'd3);
    chk("cycle_cnt", cyc0, 32'd11);
`endif

    instr(4'b0100, 3'b000, 1'b1);
    sb_q.push_back(FE_L); sb_q.push_back(DEC);
    sb_q.push_back(BR_T);
    drain("beq_z1");
    instr(4'b0101, 3'b000, 1'b1);
    sb_q.push_back(FE_L); sb_q.push_back(DEC);
    sb_q.push_back(BR_N);
    drain("bne_z1");
    instr(4'b0100, 3'b000, 1'b0);
    sb_q.push_back(FE_L); sb_q.push_back(DEC);
    sb_q.push_back(BR_N);
    drain("beq_z0");
    instr(4'b0101, 3'b000, 1'b0);
    sb_q.push_back(FE_L); sb_q.push_back(DEC);
    sb_q.push_back(BR_T);
    drain("bne_z0");
    instr(4'b1010, 3'b000, 1'b0);
    sb_q.push_back(FE_L); sb_q.push_back(DEC_ILL);
    drain("ill_op");
    instr(4'b0000, 3'b111, 1'b0);
    sb_q.push_back(FE_L); sb_q.push_back(DEC);
    sb_q.push_back(EXR_ILL);
    drain("ill_fn");
    instr(4'b0001, 3'b000, 1'b0);
    sb_q.push_back(FE_L); sb_q.push_back(DEC);
    sb_q.push_back(EXI_ADD); sb_q.push_back(WBI);
    drain("addi");
    instr(4'b0111, 3'b000, 1'b0);
    sb_q.push_back(FE_L); sb_q.push_back(DEC);
    sb_q.push_back(EXI_SLT); sb_q.push_back(WBI);
    drain("slti");
    instr(4'b0010, 3'b000, 1'b0);
    sb_q.push_back(FE_L); sb_q.push_back(DEC);
    sb_q.push_back(MADR); sb_q.push_back(MRD);
    sb_q.push_back(MWB); sb_q.push_back(FE_L);
    drain("lw0");

    rst0 = 1'b0;
    sel  = 1'b1;
    rst2 = 1'b1;
    @(posedge clk);
    #1;
    instr(4'b0010, 3'b000, 1'b0);
    sb_q.push_back(FE_W); sb_q.push_back(FE_W);
    sb_q.push_back(FE_L); sb_q.push_back(DEC);
    sb_q.push_back(MADR); sb_q.push_back(MRD);
    sb_q.push_back(MRD); sb_q.push_back(MRD);
    sb_q.push_back(MWB);
    drain("lw2");
    sb_q.push_back(FE_W); sb_q.push_back(FE_W);
    sb_q.push_back(FE_L); sb_q.push_back(DEC);
    sb_q.push_back(MADR); sb_q.push_back(MRD);
    drain("lw2_part");
    rst2 = 1'b0;
    sb_q.push_back(MRD); sb_q.push_back(INIT0);
    sb_q.push_back(INIT0);
    drain("mid_rst");
    rst2 = 1'b1;
    sb_q.push_back(INIT0); sb_q.push_back(FE_W);
    drain("rst_rel");
    instr(4'b0011, 3'b000, 1'b0);
    sb_q.push_back(FE_W); sb_q.push_back(FE_L);
    sb_q.push_back(DEC); sb_q.push_back(MADR);
    sb_q.push_back(MWR); sb_q.push_back(MWR);
    sb_q.push_back(MWR); sb_q.push_back(FE_W);
    drain("sw2");
`ifdef MC_PERF_COUNT_EN
    chk("instr_cnt2", ins2, 32'd1);
    chk("cycle_cnt2", cyc2, 32'd9);
`endif

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle controller directly upstream of the 16-bit ALU.
- Decodes the 16-bit instruction held in the IR and sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
- Drives the ALU 4-bit OP plus all datapath mux selects and write enables.
- Consumes the ALU ZERO flag for conditional branches.

Parameters:
- MEM_LAT, 0: extra wait cycles per memory access (0..15). Each access holds its memory state for 1+MEM_LAT cycles.

Ports:
- CLK  in  1  system clock, rising edge
- RESET_N  in  1  synchronous active-low reset
- OPCODE  in  4  IR[15:12]
- FUNCT  in  3  IR[2:0], R-type function
- ZERO  in  1  ALU zero flag, combinational, same cycle
- PC_WRITE  out  1  PC load enable
- IR_WRITE  out  1  IR load enable
- IORD  out  1  memory address select: 0=PC, 1=ALUOut
- MEM_READ  out  1  memory read strobe
- MEM_WRITE  out  1  memory write strobe
- REG_WRITE  out  1  register-file write enable
- REG_DST  out  1  destination: 0=rt, 1=rd
- MEM_TO_REG  out  1  write-back data: 0=ALUOut, 1=MDR
- ALU_SRC_A  out  1  0=PC, 1=regA
- ALU_SRC_B  out  2  00=regB, 01=const 1, 10=sign-ext imm, 11=sign-ext imm (branch offset)
- PC_SRC  out  2  00=ALU result, 01=ALUOut, 10=jump target
- ALU_OP  out  4  connects directly to the ALU OP input
- ILLEGAL  out  1  one-cycle pulse on an undefined opcode or funct
- STATE  out  4  current state encoding, for debug

Behaviour:
- Clock and reset:
  - Single clock domain.
  - RESET_N is synchronous and active-low.
  - While RESET_N=0 at a CLK edge: the state register loads INIT and the wait counter clears to 0.
- Output style:
  - Outputs are a Moore decode of the state register.
  - Exception: PC_WRITE in BRANCH is state AND a ZERO-derived condition.
- INIT:
  - All outputs 0, ALU_OP=AND (0000), STATE=0.
  - The first edge with RESET_N=1 moves to FETCH.
  - Reset asserted mid-instruction aborts it at the next edge; no partial write occurs after that edge.
- ALU_OP encoding: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111.
- FETCH:
  - Drives MEM_READ=1, IORD=0, ALU_SRC_A=0, ALU_SRC_B=01, ALU_OP=ADD, PC_SRC=00.
  - Waits until wait counter = MEM_LAT, then pulses IR_WRITE=1 and PC_WRITE=1 for that one cycle and moves to DECODE.
- DECODE:
  - Drives ALU_SRC_A=0, ALU_SRC_B=11, ALU_OP=ADD (precomputes branch target into ALUOut).
  - Next state by OPCODE:
    - 0000 -> EXEC_R
    - 0001 -> EXEC_I
    - 0111 -> EXEC_I
    - 0010 -> MEM_ADDR
    - 0011 -> MEM_ADDR
    - 0100 -> BRANCH
    - 0101 -> BRANCH
    - 0110 -> JUMP
    - any other opcode -> pulse ILLEGAL, go to FETCH.
- EXEC_R:
  - Drives ALU_SRC_A=1, ALU_SRC_B=00.
  - FUNCT map: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT.
  - FUNCT 101..111: ILLEGAL pulse, go to FETCH, no register write.
  - Otherwise next state is WB_R.
- EXEC_I:
  - Drives ALU_SRC_A=1, ALU_SRC_B=10.
  - ALU_OP=ADD for opcode 0001, SLT for opcode 0111.
  - Next state is WB_I.
- WB_R: REG_WRITE=1, REG_DST=1, MEM_TO_REG=0; then FETCH.
- WB_I: REG_WRITE=1, REG_DST=0, MEM_TO_REG=0; then FETCH.
- MEM_ADDR:
  - Drives ALU_SRC_A=1, ALU_SRC_B=10, ALU_OP=ADD.
  - Next state: LW -> MEM_RD, SW -> MEM_WR.
- MEM_RD: IORD=1, MEM_READ=1; held 1+MEM_LAT cycles; then MEM_WB.
- MEM_WR: IORD=1, MEM_WRITE=1; held 1+MEM_LAT cycles; then FETCH.
- MEM_WB: REG_WRITE=1, REG_DST=0, MEM_TO_REG=1; then FETCH.
- BRANCH:
  - Drives ALU_SRC_A=1, ALU_SRC_B=00, ALU_OP=SUB, PC_SRC=01.
  - PC_WRITE = ZERO for BEQ, ~ZERO for BNE.
  - Then FETCH.
- JUMP: PC_SRC=10, PC_WRITE=1; then FETCH.
- Wait counter:
  - 4 bits; counts only in FETCH, MEM_RD and MEM_WR.
  - Clears on every state change.
  - Strobes stay asserted for the whole hold period.
- Cycles per instruction (MEM_LAT=0):
  - BEQ/BNE/J: 3
  - R-type/ADDI/SLTI/SW: 4
  - LW: 5
  - Each memory access adds MEM_LAT cycles.
- Exclusivity:
  - MEM_READ and MEM_WRITE are never asserted together.
  - REG_WRITE and PC_WRITE are never asserted together.

Optional Feature:
- Macro: MC_PERF_COUNT_EN.
- Defined:
  - Adds outputs CYCLE_CNT[31:0] and INSTR_CNT[31:0].
  - CYCLE_CNT increments every cycle outside INIT.
  - INSTR_CNT increments on each transition into FETCH from a completing state, excluding INIT->FETCH and ILLEGAL exits.
  - Both counters clear on reset and wrap at 2^32.
- Undefined: neither port nor the logic exists.

Decomposition:
- Package mc_ctrl_pkg holds:
  - the state enum (INIT..JUMP, 4-bit);
  - opcode constants;
  - funct constants;
  - ALU_OP constants;
  - ALU_SRC_B and PC_SRC select constants.
- One natural sub-module: alu_op_decode, a combinational map of (state, OPCODE, FUNCT) to ALU_OP and an illegal-funct flag.

Test Plan:
- Reset: RESET_N=0 for 3 cycles mid-LW -> STATE=INIT and all enables 0; one cycle after release STATE=FETCH with MEM_READ=1.
- R-type ADD (OPCODE=0000, FUNCT=010), MEM_LAT=0 -> 4 cycles; ALU_OP=0010 in EXEC_R; REG_WRITE=1 with REG_DST=1 in cycle 4.
- LW with MEM_LAT=2 -> FETCH holds 3 cycles with IR_WRITE only in the 3rd; MEM_RD holds 3 cycles; MEM_TO_REG=1 at write-back; 9 cycles total.
- BEQ with ZERO=1 -> PC_WRITE=1, PC_SRC=01, ALU_OP=0110. BNE with ZERO=1 -> PC_WRITE=0.
- OPCODE=1010 -> ILLEGAL pulses 1 cycle in DECODE, then FETCH; FUNCT=111 -> ILLEGAL in EXEC_R with no REG_WRITE.
- MC_PERF_COUNT_EN: run ADD, SW, J -> INSTR_CNT=3 and CYCLE_CNT=11 (counted from the first FETCH).
